mpu_panel_responder: RTL and testbench

- Synthesizable responder (panel side) of the 8080-style MPU parallel bus driven by mpu_interface.
- Sits in the TFT test designs as a loopback target that stands in for a real panel.
- Samples CSX/DCX/WRX/RDX/D and decodes the command set: SWRESET, SLPOUT, DISPON/DISPOFF, CASET, PASET, RAMWR, RAMRD, RDDID.
- Keeps the column/page window and address pointers, issues pixel writes and reads on a frame-buffer port, and drives read data back onto the bus.

---
 rtl/mpu_panel_responder.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_mpu_panel_responder.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_panel_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mpu_panel_responder : panel-side responder for the 8080-style MPU bus      |
// | Rev 1.0 - initial release                                                  |
// +--------------------------------------------------------------------------+
module mpu_panel_responder #(
  parameter int          DATA_WIDTH  = 24,
  parameter int          HRES_WIDTH  = 9,
  parameter int          VRES_WIDTH  = 10,
  parameter int          SYNC_STAGES = 2,
  parameter logic [23:0] PANEL_ID    = 24'h009341
) (
  input  logic                  i_sysclk,
  input  logic                  w_srst,
  input  logic                  i_csx,
  input  logic                  i_dcx,
  input  logic                  i_wrx,
  input  logic                  i_rdx,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic [DATA_WIDTH-1:0] o_d,
  output logic [DATA_WIDTH-1:0] o_oe,
  output logic                  o_px_we,
  output logic                  o_px_re,
  output logic [HRES_WIDTH-1:0] o_px_x,
  output logic [VRES_WIDTH-1:0] o_px_y,
  output logic [DATA_WIDTH-1:0] o_px_rgb,
  input  logic [DATA_WIDTH-1:0] i_px_rgb,
  output logic [7:0]            o_cmd,
  output logic                  o_sleep_out,
  output logic                  o_display_on,
  output logic                  o_unknown
);

  localparam logic [7:0] c_CMD_SWRESET = 8'h01;
  localparam logic [7:0] c_CMD_RDDID   = 8'h04;
  localparam logic [7:0] c_CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] c_CMD_DISPOFF = 8'h28;
  localparam logic [7:0] c_CMD_DISPON  = 8'h29;
  localparam logic [7:0] c_CMD_CASET   = 8'h2A;
  localparam logic [7:0] c_CMD_PASET   = 8'h2B;
  localparam logic [7:0] c_CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] c_CMD_RAMRD   = 8'h2E;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CASET = 3'd1,
    S_PASET = 3'd2,
    S_RAMWR = 3'd3,
    S_RAMRD = 3'd4,
    S_RDID  = 3'd5
  } state_t;

  // Input synchronizers; strobes idle high so reset does not fake an edge.
  logic [SYNC_STAGES-1:0]                 r_csx_sync;
  logic [SYNC_STAGES-1:0]                 r_dcx_sync;
  logic [SYNC_STAGES-1:0]                 r_wrx_sync;
  logic [SYNC_STAGES-1:0]                 r_rdx_sync;
  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] r_d_sync;
  logic                                   r_wrx_prev;
  logic                                   r_rdx_prev;

  always_ff @(posedge i_sysclk or posedge w_srst) begin
    if (w_srst) begin
      r_csx_sync <= '1;
      r_dcx_sync <= '0;
      r_wrx_sync <= '1;
      r_rdx_sync <= '1;
      r_d_sync   <= '0;
      r_wrx_prev <= 1'b1;
      r_rdx_prev <= 1'b1;
    end else begin
      r_csx_sync <= {r_csx_sync[SYNC_STAGES-2:0], i_csx};
      r_dcx_sync <= {r_dcx_sync[SYNC_STAGES-2:0], i_dcx};
      r_wrx_sync <= {r_wrx_sync[SYNC_STAGES-2:0], i_wrx};
      r_rdx_sync <= {r_rdx_sync[SYNC_STAGES-2:0], i_rdx};
      r_d_sync   <= {r_d_sync[SYNC_STAGES-2:0], i_d};
      r_wrx_prev <= r_wrx_sync[SYNC_STAGES-1];
      r_rdx_prev <= r_rdx_sync[SYNC_STAGES-1];
    end
  end

  logic                  w_csx;
  logic                  w_dcx;
  logic                  w_wrx;
  logic                  w_rdx;
  logic [DATA_WIDTH-1:0] w_d;
  logic [7:0]            w_byte;
  logic                  w_wr_ev;
  logic                  w_rd_ev;
  logic                  w_rd_rise;

  assign w_csx     = r_csx_sync[SYNC_STAGES-1];
  assign w_dcx     = r_dcx_sync[SYNC_STAGES-1];
  assign w_wrx     = r_wrx_sync[SYNC_STAGES-1];
  assign w_rdx     = r_rdx_sync[SYNC_STAGES-1];
  assign w_d       = r_d_sync[SYNC_STAGES-1];
  assign w_byte    = w_d[7:0];
  assign w_wr_ev   = ~w_csx & w_wrx & ~r_wrx_prev;
  // A write wins over a simultaneous read.
  assign w_rd_ev   = ~w_csx & ~w_rdx & r_rdx_prev & ~w_wr_ev;
  assign w_rd_rise = w_rdx & ~r_rdx_prev;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_unknown;
  logic [HRES_WIDTH-1:0] r_sc;
  logic [HRES_WIDTH-1:0] r_ec;
  logic [VRES_WIDTH-1:0] r_sp;
  logic [VRES_WIDTH-1:0] r_ep;
  logic [HRES_WIDTH-1:0] r_x;
  logic [VRES_WIDTH-1:0] r_y;
  logic [HRES_WIDTH-1:0] w_x_adv;
  logic [VRES_WIDTH-1:0] w_y_adv;
  logic [2:0]            r_pcnt;
  logic                  r_dummy;
  logic [23:0]           r_pbuf;
  logic [15:0]           w_end;
  logic                  r_re_d;
  logic [7:0]            w_id_byte;
  logic                  w_unused;

  // Parameter bytes arrive MSB first: r_pbuf holds {start_hi, start_lo, end_hi}.
  assign w_end    = {r_pbuf[7:0], w_byte};
  assign w_unused = ^{r_pbuf, w_end};

  always_comb begin
    w_state_nxt = r_state;
    w_unknown   = 1'b0;
    if (w_csx) begin
      w_state_nxt = S_IDLE;
    end else if (w_wr_ev) begin
      if (!w_dcx) begin
        case (w_byte)
          c_CMD_CASET: w_state_nxt = S_CASET;
          c_CMD_PASET: w_state_nxt = S_PASET;
          c_CMD_RAMWR: w_state_nxt = S_RAMWR;
          c_CMD_RAMRD: w_state_nxt = S_RAMRD;
          c_CMD_RDDID: w_state_nxt = S_RDID;
          c_CMD_SWRESET, c_CMD_SLPOUT, c_CMD_DISPON, c_CMD_DISPOFF:
            w_state_nxt = S_IDLE;
          default: begin
            w_state_nxt = S_IDLE;
            w_unknown   = 1'b1;
          end
        endcase
      end else if ((r_state == S_CASET || r_state == S_PASET) && r_pcnt == 3'd3) begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_comb begin
    w_x_adv = r_x;
    w_y_adv = r_y;
    if (r_x != r_ec) begin
      w_x_adv = r_x + HRES_WIDTH'(1);
    end else begin
      w_x_adv = r_sc;
      if (r_y != r_ep) w_y_adv = r_y + VRES_WIDTH'(1);
      else             w_y_adv = r_sp;
    end
  end

  always_comb begin
    case (r_pcnt)
      3'd1:    w_id_byte = PANEL_ID[23:16];
      3'd2:    w_id_byte = PANEL_ID[15:8];
      3'd3:    w_id_byte = PANEL_ID[7:0];
      default: w_id_byte = 8'h00;
    endcase
  end

  always_ff @(posedge i_sysclk or posedge w_srst) begin
    if (w_srst) begin
      r_state      <= S_IDLE;
      r_sc         <= '0;
      r_ec         <= '1;
      r_sp         <= '0;
      r_ep         <= '1;
      r_x          <= '0;
      r_y          <= '0;
      r_pcnt       <= '0;
      r_dummy      <= 1'b1;
      r_pbuf       <= '0;
      r_re_d       <= 1'b0;
      o_d          <= '0;
      o_oe         <= '0;
      o_px_we      <= 1'b0;
      o_px_re      <= 1'b0;
      o_px_x       <= '0;
      o_px_y       <= '0;
      o_px_rgb     <= '0;
      o_cmd        <= '0;
      o_sleep_out  <= 1'b0;
      o_display_on <= 1'b0;
      o_unknown    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      o_unknown <= w_unknown;
      o_px_we   <= 1'b0;
      o_px_re   <= 1'b0;
      // Frame buffer answers one cycle after the read strobe.
      r_re_d    <= o_px_re;
      if (r_re_d) o_d <= i_px_rgb;
      if (w_csx || w_rd_rise) o_oe <= '0;

      if (w_csx) begin
        r_pcnt <= '0;
      end else if (w_wr_ev) begin
        if (!w_dcx) begin
          o_cmd  <= w_byte;
          r_pcnt <= '0;
          case (w_byte)
            c_CMD_SWRESET: begin
              r_sc         <= '0;
              r_ec         <= '1;
              r_sp         <= '0;
              r_ep         <= '1;
              o_sleep_out  <= 1'b0;
              o_display_on <= 1'b0;
            end
            c_CMD_SLPOUT:  o_sleep_out  <= 1'b1;
            c_CMD_DISPON:  o_display_on <= 1'b1;
            c_CMD_DISPOFF: o_display_on <= 1'b0;
            c_CMD_RAMWR: begin
              r_x <= r_sc;
              r_y <= r_sp;
            end
            c_CMD_RAMRD: begin
              r_x     <= r_sc;
              r_y     <= r_sp;
              r_dummy <= 1'b1;
            end
            default: ;
          endcase
        end else begin
          case (r_state)
            S_CASET, S_PASET: begin
              r_pbuf <= {r_pbuf[15:0], w_byte};
              r_pcnt <= r_pcnt + 3'd1;
              if (r_pcnt == 3'd3) begin
                if (r_state == S_CASET) begin
                  r_sc <= r_pbuf[HRES_WIDTH+7:8];
                  r_ec <= w_end[HRES_WIDTH-1:0];
                end else begin
                  r_sp <= r_pbuf[VRES_WIDTH+7:8];
                  r_ep <= w_end[VRES_WIDTH-1:0];
                end
              end
            end
            S_RAMWR: begin
              o_px_we  <= 1'b1;
              o_px_x   <= r_x;
              o_px_y   <= r_y;
              o_px_rgb <= w_d;
              r_x      <= w_x_adv;
              r_y      <= w_y_adv;
            end
            default: ;
          endcase
        end
      end else if (w_rd_ev) begin
        case (r_state)
          S_RAMRD: begin
            o_oe <= '1;
            if (r_dummy) begin
              o_d     <= '0;
              r_dummy <= 1'b0;
            end else begin
              o_px_re <= 1'b1;
              o_px_x  <= r_x;
              o_px_y  <= r_y;
              r_x     <= w_x_adv;
              r_y     <= w_y_adv;
            end
          end
          S_RDID: begin
            o_oe <= '1;
            o_d  <= DATA_WIDTH'(w_id_byte);
            if (r_pcnt != 3'd4) r_pcnt <= r_pcnt + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mpu_panel_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mpu_panel_responder : self-checking bench for mpu_panel_responder      |
// | Rev 1.0 - initial release                                                  |
// +--------------------------------------------------------------------------+
module tb_mpu_panel_responder;

  localparam int DW = 24;
  localparam int HW = 9;
  localparam int VW = 10;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          csx, dcx, wrx, rdx;
  logic [DW-1:0] d, dout, doe, px_rgb_out, px_rgb_in;
  logic          px_we, px_re, sleep_out, display_on, unknown;
  logic [HW-1:0] px_x;
  logic [VW-1:0] px_y;
  logic [7:0]    cmd;

  always #5 clk = ~clk;

  mpu_panel_responder #(
    .DATA_WIDTH(DW), .HRES_WIDTH(HW), .VRES_WIDTH(VW),
    .SYNC_STAGES(SS), .PANEL_ID(24'h009341)
  ) dut (
    .i_sysclk(clk), .w_srst(rst), .i_csx(csx), .i_dcx(dcx), .i_wrx(wrx),
    .i_rdx(rdx), .i_d(d), .o_d(dout), .o_oe(doe), .o_px_we(px_we),
    .o_px_re(px_re), .o_px_x(px_x), .o_px_y(px_y), .o_px_rgb(px_rgb_out),
    .i_px_rgb(px_rgb_in), .o_cmd(cmd), .o_sleep_out(sleep_out),
    .o_display_on(display_on), .o_unknown(unknown)
  );

  function automatic logic [DW-1:0] fb(input int x, input int y);
    return DW'(x + 16 * y);
  endfunction

  // Frame buffer: content is a function of the address, one cycle latency.
  initial px_rgb_in = '0;
  always @(posedge clk) if (px_re) px_rgb_in <= fb(int'(px_x), int'(px_y));

  int checks = 0;
  int errors = 0;
  logic [HW+VW+DW-1:0] obs_wr[$];
  logic [HW+VW+DW-1:0] exp_wr[$];
  int n_re  = 0;
  int n_unk = 0;

  always @(negedge clk) begin
    if (px_we)   obs_wr.push_back({px_x, px_y, px_rgb_out});
    if (px_re)   n_re++;
    if (unknown) n_unk++;
  end

  // ---------------- reference model (transaction level) ----------------
  int m_sc, m_ec, m_sp, m_ep, m_x, m_y, m_pcnt, m_rdidx;
  int m_par[4];
  logic [7:0] m_mode;
  bit m_dummy, m_sleep, m_disp;

  task automatic model_reset();
    m_sc = 0; m_ec = 511; m_sp = 0; m_ep = 1023; m_x = 0; m_y = 0;
    m_pcnt = 0; m_rdidx = 0; m_mode = 8'h00; m_dummy = 1; m_sleep = 0; m_disp = 0;
  endtask

  task automatic model_advance();
    if (m_x != m_ec) m_x = (m_x + 1) % 512;
    else begin
      m_x = m_sc;
      if (m_y != m_ep) m_y = (m_y + 1) % 1024;
      else m_y = m_sp;
    end
  endtask

  task automatic model_write(input logic dc, input logic [DW-1:0] v);
    if (!dc) begin
      m_mode = v[7:0];
      m_pcnt = 0;
      case (v[7:0])
        8'h01: begin m_sc = 0; m_ec = 511; m_sp = 0; m_ep = 1023; m_sleep = 0; m_disp = 0; m_mode = 0; end
        8'h11: begin m_sleep = 1; m_mode = 0; end
        8'h29: begin m_disp = 1; m_mode = 0; end
        8'h28: begin m_disp = 0; m_mode = 0; end
        8'h2A, 8'h2B: ;
        8'h2C: begin m_x = m_sc; m_y = m_sp; end
        8'h2E: begin m_x = m_sc; m_y = m_sp; m_dummy = 1; end
        8'h04: m_rdidx = 0;
        default: m_mode = 0;
      endcase
    end else if (m_mode == 8'h2A || m_mode == 8'h2B) begin
      m_par[m_pcnt] = int'(v[7:0]);
      m_pcnt++;
      if (m_pcnt == 4) begin
        if (m_mode == 8'h2A) begin
          m_sc = (m_par[0] * 256 + m_par[1]) % 512;
          m_ec = (m_par[2] * 256 + m_par[3]) % 512;
        end else begin
          m_sp = (m_par[0] * 256 + m_par[1]) % 1024;
          m_ep = (m_par[2] * 256 + m_par[3]) % 1024;
        end
        m_mode = 0;
      end
    end else if (m_mode == 8'h2C) begin
      exp_wr.push_back({HW'(m_x), VW'(m_y), v});
      model_advance();
    end
  endtask

  task automatic model_read(output logic [DW-1:0] e);
    e = '0;
    if (m_mode == 8'h2E) begin
      if (m_dummy) m_dummy = 0;
      else begin e = fb(m_x, m_y); model_advance(); end
    end else if (m_mode == 8'h04) begin
      case (m_rdidx)
        1: e = DW'(8'h00);
        2: e = DW'(8'h93);
        3: e = DW'(8'h41);
        default: e = '0;
      endcase
      m_rdidx++;
    end
  endtask

  // ---------------- bus master ----------------
  task automatic bus_write(input logic dc, input logic [DW-1:0] v);
    csx = 1'b0; dcx = dc; d = v; wrx = 1'b0;
    repeat (4) @(negedge clk);
    wrx = 1'b1;
    repeat (4) @(negedge clk);
    model_write(dc, v);
  endtask

  task automatic bus_read(output logic [DW-1:0] od, output logic [DW-1:0] oe);
    csx = 1'b0; rdx = 1'b0;
    repeat (SS + 4) @(negedge clk);
    od = dout; oe = doe;
    rdx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    csx = 1'b1;
    repeat (5) @(negedge clk);
    m_mode = 0; m_pcnt = 0;
  endtask

  task automatic win(input logic [7:0] c, input int s, input int e);
    bus_write(1'b0, DW'(c));
    bus_write(1'b1, DW'(s[15:8])); bus_write(1'b1, DW'(s[7:0]));
    bus_write(1'b1, DW'(e[15:8])); bus_write(1'b1, DW'(e[7:0]));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; csx = 1'b1; dcx = 1'b0; wrx = 1'b1; rdx = 1'b1; d = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({dout, doe, px_rgb_out} !== '0) begin
      errors++; $display("FAIL reset_data: o_d=%h o_oe=%h o_px_rgb=%h required 0", dout, doe, px_rgb_out);
    end
    checks++;
    if ({px_we, px_re, px_x, px_y, cmd, sleep_out, display_on, unknown} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: we=%b re=%b x=%0d y=%0d cmd=%h sl=%b dp=%b unk=%b required all 0",
               px_we, px_re, px_x, px_y, cmd, sleep_out, display_on, unknown);
    end
  endtask

  task automatic test_ramwr();
    int ex[9] = '{2, 3, 4, 2, 3, 4, 2, 3, 4};
    int ey[9] = '{1, 1, 1, 2, 2, 2, 1, 1, 1};
    obs_wr.delete(); exp_wr.delete();
    win(8'h2A, 2, 4);
    win(8'h2B, 1, 2);
    bus_write(1'b0, DW'(8'h2C));
    for (int i = 1; i <= 9; i++) bus_write(1'b1, DW'(i));
    repeat (4) @(negedge clk);
    checks++;
    if (obs_wr.size() != 9) begin
      errors++; $display("FAIL ramwr_count: got %0d pixel writes required 9", obs_wr.size());
    end
    for (int i = 0; i < 9 && i < obs_wr.size(); i++) begin
      checks++;
      if (obs_wr[i] !== {HW'(ex[i]), VW'(ey[i]), DW'(i + 1)}) begin
        errors++;
        $display("FAIL ramwr_px%0d: got (%0d,%0d)=%0h required (%0d,%0d)=%0h", i,
                 obs_wr[i][HW+VW+DW-1:VW+DW], obs_wr[i][VW+DW-1:DW], obs_wr[i][DW-1:0], ex[i], ey[i], i + 1);
      end
    end
  endtask

  task automatic test_ramrd();
    logic [DW-1:0] od, oe, e;
    logic [DW-1:0] req[3] = '{24'h0, 24'h12, 24'h13};
    int re0;
    bus_write(1'b0, DW'(8'h2E));
    re0 = n_re;
    for (int i = 0; i < 3; i++) begin
      bus_read(od, oe);
      model_read(e);
      checks++;
      if (od !== req[i] || oe !== '1) begin
        errors++; $display("FAIL ramrd_%0d: o_d=%h o_oe=%h required o_d=%h o_oe=ffffff", i, od, oe, req[i]);
      end
      if (i == 0) begin
        checks++;
        if (n_re != re0) begin
          errors++; $display("FAIL ramrd_dummy_re: got %0d px reads required 0", n_re - re0);
        end
      end
    end
    checks++;
    if (n_re - re0 != 2) begin
      errors++; $display("FAIL ramrd_re_count: got %0d required 2", n_re - re0);
    end
    checks++;
    if (doe !== '0) begin
      errors++; $display("FAIL ramrd_oe_release: o_oe=%h required 0", doe);
    end
  endtask

  task automatic test_rdid();
    logic [DW-1:0] od, oe, e;
    logic [DW-1:0] req[5] = '{24'h0, 24'h00, 24'h93, 24'h41, 24'h0};
    int u0;
    bus_write(1'b0, DW'(8'h04));
    for (int i = 0; i < 5; i++) begin
      bus_read(od, oe);
      model_read(e);
      checks++;
      if (od !== req[i] || oe !== '1) begin
        errors++; $display("FAIL rdid_%0d: o_d=%h o_oe=%h required o_d=%h o_oe=ffffff", i, od, oe, req[i]);
      end
    end
    u0 = n_unk;
    bus_write(1'b0, DW'(8'hFF));
    checks++;
    if (n_unk - u0 != 1 || cmd !== 8'hFF) begin
      errors++; $display("FAIL unknown_cmd: pulses=%0d cmd=%h required pulses=1 cmd=ff", n_unk - u0, cmd);
    end
  endtask

  task automatic test_caset_abort();
    int ex[3] = '{5, 6, 5};
    int ey[3] = '{0, 0, 1};
    obs_wr.delete(); exp_wr.delete();
    bus_write(1'b0, DW'(8'h2A));
    bus_write(1'b1, DW'(8'h00));
    bus_write(1'b1, DW'(8'h09));
    cs_high();
    win(8'h2A, 5, 6);
    win(8'h2B, 0, 1);
    bus_write(1'b0, DW'(8'h2C));
    for (int i = 0; i < 3; i++) bus_write(1'b1, DW'(24'hA0 + i));
    repeat (4) @(negedge clk);
    checks++;
    if (obs_wr.size() != 3) begin
      errors++; $display("FAIL abort_count: got %0d pixel writes required 3", obs_wr.size());
    end
    for (int i = 0; i < 3 && i < obs_wr.size(); i++) begin
      checks++;
      if (obs_wr[i] !== {HW'(ex[i]), VW'(ey[i]), DW'(24'hA0 + i)}) begin
        errors++; $display("FAIL abort_px%0d: got %h required (%0d,%0d)", i, obs_wr[i], ex[i], ey[i]);
      end
    end
  endtask

  task automatic test_power();
    logic [7:0] c[4] = '{8'h11, 8'h29, 8'h28, 8'h01};
    logic [1:0] req[4] = '{2'b10, 2'b11, 2'b10, 2'b00};
    obs_wr.delete(); exp_wr.delete();
    for (int i = 0; i < 4; i++) begin
      bus_write(1'b0, DW'(c[i]));
      checks++;
      if ({sleep_out, display_on} !== req[i] || cmd !== c[i]) begin
        errors++; $display("FAIL power_%h: sleep/disp=%b cmd=%h required %b cmd=%h", c[i], {sleep_out, display_on}, cmd, req[i], c[i]);
      end
    end
    bus_write(1'b0, DW'(8'h2C));
    bus_write(1'b1, DW'(24'h111111));
    bus_write(1'b1, DW'(24'h222222));
    repeat (4) @(negedge clk);
    checks++;
    if (obs_wr.size() != 2 || obs_wr[0] !== {HW'(0), VW'(0), DW'(24'h111111)} ||
        obs_wr[1] !== {HW'(1), VW'(0), DW'(24'h222222)}) begin
      errors++; $display("FAIL swreset_window: got %0d writes, first %h, required (0,0) then (1,0)",
                         obs_wr.size(), obs_wr.size() > 0 ? obs_wr[0] : '0);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] od, oe, e, o;
    int s, en, nw, nr;
    for (int it = 0; it < 4; it++) begin
      obs_wr.delete(); exp_wr.delete();
      s  = int'($urandom_range(0, 65535));
      en = (((s % 512) + int'($urandom_range(0, 3))) % 512) | (int'($urandom_range(0, 127)) << 9);
      win(8'h2A, s, en);
      s  = int'($urandom_range(0, 65535));
      en = (((s % 1024) + int'($urandom_range(0, 2))) % 1024) | (int'($urandom_range(0, 63)) << 10);
      win(8'h2B, s, en);
      bus_write(1'b0, DW'(8'h2C));
      nw = int'($urandom_range(1, 12));
      for (int i = 0; i < nw; i++) bus_write(1'b1, DW'($urandom));
      repeat (4) @(negedge clk);
      checks++;
      if (obs_wr.size() != exp_wr.size()) begin
        errors++; $display("FAIL rand%0d_count: got %0d writes required %0d", it, obs_wr.size(), exp_wr.size());
      end
      while (exp_wr.size() > 0) begin
        e = '0;
        o = '0;
        checks++;
        if (obs_wr.size() == 0) begin
          void'(exp_wr.pop_front());
          errors++; $display("FAIL rand%0d_px: missing pixel write", it);
        end else begin
          logic [HW+VW+DW-1:0] ew, ow;
          ew = exp_wr.pop_front(); ow = obs_wr.pop_front();
          if (ow !== ew) begin
            errors++; $display("FAIL rand%0d_px: got %h required %h", it, ow, ew);
          end
        end
      end
      bus_write(1'b0, DW'(8'h2E));
      nr = int'($urandom_range(2, 6));
      for (int i = 0; i < nr; i++) begin
        bus_read(od, oe);
        model_read(e);
        checks++;
        if (od !== e || oe !== '1) begin
          errors++; $display("FAIL rand%0d_rd%0d: o_d=%h o_oe=%h required o_d=%h", it, i, od, oe, e);
        end
      end
      cs_high();
    end
  endtask

  task automatic test_reset_midop();
    obs_wr.delete(); exp_wr.delete();
    bus_write(1'b0, DW'(8'h2C));
    csx = 1'b0; dcx = 1'b1; d = DW'(24'h55); wrx = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (cmd !== 8'h00 || sleep_out !== 1'b0 || doe !== '0) begin
      errors++; $display("FAIL async_reset: cmd=%h sleep=%b oe=%h required 0", cmd, sleep_out, doe);
    end
    @(negedge clk);
    csx = 1'b1; wrx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    bus_write(1'b0, DW'(8'h2C));
    bus_write(1'b1, DW'(24'h77));
    repeat (4) @(negedge clk);
    checks++;
    if (obs_wr.size() != 1 || obs_wr[0] !== {HW'(0), VW'(0), DW'(24'h77)}) begin
      errors++; $display("FAIL reset_window: %0d writes, first %h, required one at (0,0)",
                         obs_wr.size(), obs_wr.size() > 0 ? obs_wr[0] : '0);
    end
  endtask

  initial begin
    test_reset();
    test_ramwr();
    test_ramrd();
    test_rdid();
    test_caset_abort();
    test_power();
    test_random();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
